// File: rtl/dot_seq_ctrl.sv
// dot_seq_ctrl
//   Sequencer that owns all control of the MAC accumulator datapath for one
//   dot product. On start it clears the MAC and streams cnt operand pairs
//   from the A/B vector SRAMs (shared address, sync read). It then waits one
//   drain cycle for the last accumulate, captures the MAC value into result
//   and pulses done.
//
// Optional feature macro: DOT_SEQ_STALL_EN
//   When defined, a stall input is added. stall=1 in FETCH suppresses the
//   read for that cycle and holds the address counter.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, len            launch request and vector length (sampled in IDLE)
//   stall                 fetch stall (only with DOT_SEQ_STALL_EN)
//   busy, done, result    status, one-cycle completion pulse, captured sum
//   mem_rd, mem_addr      shared SRAM read enable and address
//   mem_a_data/b_data     SRAM read data, valid one cycle after mem_rd
//   mac_a, mac_b          MAC operands (combinational pass of SRAM data)
//   mac_en, mac_clr       MAC accumulate enable and clear
//   mac_acc               MAC accumulator value
module dot_seq_ctrl #(
    parameter int P_WIDTH  = 32,
    parameter int P_ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [P_ADDR_W:0]   len,
`ifdef DOT_SEQ_STALL_EN
    input  logic                stall,
`endif
    output logic                busy,
    output logic                done,
    output logic [P_WIDTH-1:0]  result,
    output logic                mem_rd,
    output logic [P_ADDR_W-1:0] mem_addr,
    input  logic [P_WIDTH-1:0]  mem_a_data,
    input  logic [P_WIDTH-1:0]  mem_b_data,
    output logic [P_WIDTH-1:0]  mac_a,
    output logic [P_WIDTH-1:0]  mac_b,
    output logic                mac_en,
    output logic                mac_clr,
    input  logic [P_WIDTH-1:0]  mac_acc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FETCH,
        S_DRAIN,
        S_CAPT
    } state_t;

    localparam logic [P_ADDR_W:0] MAX_LEN = {1'b1, {P_ADDR_W{1'b0}}};
    localparam logic [P_ADDR_W:0] ONE     = {{P_ADDR_W{1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;
    logic [P_ADDR_W:0]   idx;
    logic [P_ADDR_W:0]   cnt;
    logic                stall_in;

`ifdef DOT_SEQ_STALL_EN
    assign stall_in = stall;
`else
    assign stall_in = 1'b0;
`endif

    assign busy     = (state != S_IDLE);
    assign mac_a    = mem_a_data;
    assign mac_b    = mem_b_data;
    // idx is one bit wider than the address so a full 2**P_ADDR_W run can
    // be counted. FETCH leaves before idx reaches that value, so the
    // address itself never wraps.
    assign mem_addr = idx[P_ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mac_clr   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                mac_clr   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (!stall_in) begin
                    mem_rd = 1'b1;
                    if ((idx + ONE) == cnt) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // mac_en is mem_rd delayed by the SRAM read latency, so a read issued in
    // the last FETCH cycle accumulates at the DRAIN->CAPT edge and CAPT sees
    // the final sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            mac_en <= 1'b0;
        end else begin
            done   <= 1'b0;
            mac_en <= mem_rd;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            result <= '0;
                            done   <= 1'b1;
                        end else begin
                            cnt <= (len > MAX_LEN) ? MAX_LEN : len;
                        end
                    end
                end
                S_CLR: idx <= '0;
                S_FETCH: begin
                    if (mem_rd) begin
                        idx <= idx + ONE;
                    end
                end
                S_CAPT: begin
                    result <= mac_acc;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// tb_dot_seq_ctrl
//   Self-checking bench for dot_seq_ctrl. It models the two vector SRAMs and
//   the MAC around the sequencer. Each operation is checked against a plain
//   dot-product sum, the expected latency, a read-count/address sequence and
//   the clear count.
//   Honours DOT_SEQ_STALL_EN (random stall during the random phase).
module tb_dot_seq_ctrl;

    localparam int W     = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int LIMIT = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_a_data = '0;
    logic [W-1:0]  mem_b_data = '0;
    logic [W-1:0]  mac_a;
    logic [W-1:0]  mac_b;
    logic          mac_en;
    logic          mac_clr;
    logic [W-1:0]  mac_acc = '0;
`ifdef DOT_SEQ_STALL_EN
    logic          stall = 1'b0;
    bit            stall_en = 1'b0;
`endif

    logic [W-1:0]  vec_a [DEPTH];
    logic [W-1:0]  vec_b [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_seq_ctrl #(.P_WIDTH(W), .P_ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
`ifdef DOT_SEQ_STALL_EN
        .stall      (stall),
`endif
        .busy       (busy),
        .done       (done),
        .result     (result),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_a_data (mem_a_data),
        .mem_b_data (mem_b_data),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .mac_acc    (mac_acc)
    );

    // Sync-read vector SRAMs sharing one address.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_a_data <= vec_a[mem_addr];
            mem_b_data <= vec_b[mem_addr];
        end
    end

    // MAC: clear has priority, product wraps modulo 2**W. Not reset by rst.
    always @(posedge clk) begin
        if (mac_clr) begin
            mac_acc <= '0;
        end else if (mac_en) begin
            mac_acc <= mac_acc + mac_a * mac_b;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] dotRef(input int n);
        logic [W-1:0] s;
        int m;
        s = '0;
        m = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < m; i++) begin
            s = s + vec_a[i] * vec_b[i];
        end
        return s;
    endfunction

    task automatic fillRandom();
        for (int i = 0; i < DEPTH; i++) begin
            vec_a[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 100);
            vec_b[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 100);
        end
    endtask

    task automatic fillTest1();
        fillRandom();
        for (int i = 0; i < 4; i++) begin
            vec_a[i] = W'(i + 1);
            vec_b[i] = W'(i + 5);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one operation of length n. b2b=1 raises start in the current
    // (done) cycle instead of waiting for the next negedge; poke=1 pulses a
    // spurious start mid-operation, which must be ignored.
    task automatic applyStimulus(input int n, input bit b2b, input bit poke);
        int  k;
        int  rd;
        int  en_cnt;
        int  clr_cnt;
        int  stalls;
        int  exp_len;
        bit  seen_done;
        bit  clr_done;
        logic [W-1:0] exp_res;

        rd = 0; en_cnt = 0; clr_cnt = 0; stalls = 0;
        seen_done = 1'b0; clr_done = 1'b0;
        exp_len = (n > DEPTH) ? DEPTH : n;
        exp_res = dotRef(n);

        if (!b2b) @(negedge clk);
        start = 1'b1;
        len   = n[AW:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = AW'($urandom) + 9'd1;
`ifdef DOT_SEQ_STALL_EN
        stall = stall_en && ($urandom_range(0, 2) == 0);
`endif
        for (k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (mac_en) en_cnt++;
`ifdef DOT_SEQ_STALL_EN
            if (stall && clr_done && rd < exp_len) stalls++;
`endif
            if (mem_rd) begin
                checkOutput("addr", 64'(mem_addr), 64'(rd));
                rd++;
            end
            if (mac_clr) clr_cnt++;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (clr_cnt != 0) clr_done = 1'b1;
            @(posedge clk);
            #1;
            start = poke && (k == 1);
            len   = AW'($urandom) + 9'd1;
`ifdef DOT_SEQ_STALL_EN
            stall = stall_en && ($urandom_range(0, 2) == 0);
`endif
        end
`ifdef DOT_SEQ_STALL_EN
        stall = 1'b0;
`endif
        checkOutput("done_seen", 64'(seen_done), 64'd1);
        checkOutput("latency", 64'(k), (n == 0) ? 64'd0 : 64'(exp_len + 3 + stalls));
        checkOutput("result", 64'(result), 64'(exp_res));
        checkOutput("read_count", 64'(rd), 64'(exp_len));
        checkOutput("mac_en_count", 64'(en_cnt), 64'(exp_len));
        checkOutput("clr_count", 64'(clr_cnt), (n == 0) ? 64'd0 : 64'd1);
        checkOutput("busy_at_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int  n;
        int  rd;
        logic [W-1:0] held;

        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        fillRandom();
        resetDut();

        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_mem_rd", 64'(mem_rd), 64'd0);
        checkOutput("rst_mac_en", 64'(mac_en), 64'd0);
        checkOutput("rst_mac_clr", 64'(mac_clr), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);

        // Basic run with an ignored mid-run start, then back-to-back run.
        fillTest1();
        applyStimulus(4, 1'b0, 1'b1);
        checkOutput("t1_result70", 64'(result), 64'd70);
        vec_a[0] = 32'd2; vec_a[1] = 32'd3;
        vec_b[0] = 32'd4; vec_b[1] = 32'd5;
        applyStimulus(2, 1'b1, 1'b0);
        checkOutput("b2b_result23", 64'(result), 64'd23);
        held = result;
        @(negedge clk);
        checkOutput("done_pulse", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("result_hold", 64'(result), 64'(held));

        // Zero length.
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("len0_result", 64'(result), 64'd0);

        // Reset on the third FETCH cycle.
        fillRandom();
        @(negedge clk);
        start = 1'b1;
        len   = 9'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        rd = 0;
        for (int k = 0; k < 20 && rd < 3; k++) begin
            @(negedge clk);
            if (mem_rd) rd++;
        end
        checkOutput("mid_reads", 64'(rd), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_busy", 64'(busy), 64'd0);
        checkOutput("mid_done", 64'(done), 64'd0);
        checkOutput("mid_mem_rd", 64'(mem_rd), 64'd0);
        checkOutput("mid_mac_en", 64'(mac_en), 64'd0);
        checkOutput("mid_mac_clr", 64'(mac_clr), 64'd0);
        checkOutput("mid_result", 64'(result), 64'd0);
        checkOutput("mid_mem_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0;
        fillTest1();
        applyStimulus(4, 1'b0, 1'b0);
        checkOutput("post_rst_result70", 64'(result), 64'd70);

        // Wrap and full-length boundaries, plus an over-length clamp.
        vec_a[0] = 32'h0001_0000;
        vec_b[0] = 32'h0001_0000;
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("wrap_result", 64'(result), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            vec_a[i] = 32'd1;
            vec_b[i] = 32'd1;
        end
        applyStimulus(256, 1'b0, 1'b0);
        checkOutput("full_result", 64'(result), 64'd256);
        applyStimulus(300, 1'b0, 1'b0);
        checkOutput("clamp_result", 64'(result), 64'd256);

        // Randomized operations.
`ifdef DOT_SEQ_STALL_EN
        stall_en = 1'b1;
`endif
        for (int t = 0; t < 25; t++) begin
            fillRandom();
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = 256 + $urandom_range(0, 255);
                2:       n = 256;
                default: n = $urandom_range(1, 16);
            endcase
            applyStimulus(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
